// File: rtl/pong_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// pong_pkg - FSM state codes, ball directions and clog2 helper.  Rev 1.0
//------------------------------------------------------------------------------
package pong_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RALLY = 3'd1,
    S_SHOW  = 3'd2,
    S_SERVE = 3'd3,
    S_END   = 3'd4
  } state_t;

  localparam logic LEFTWARD  = 1'b1;
  localparam logic RIGHTWARD = 1'b0;

  function automatic int clog2(input longint value);
    int     bits;
    longint rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >>> 1;
    end
    return bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pong_tick_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// pong_tick_gen - ball-step counter, pulses on terminal count.  Rev 1.0
//------------------------------------------------------------------------------
module pong_tick_gen #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] count;
  logic             last;

  // >= keeps the counter bounded if the period shrinks below the current count
  assign last = (count >= (period - CNT_W'(1)));
  assign tick = last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || last) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pong_game_core.sv
`default_nettype none
//------------------------------------------------------------------------------
// pong_game_core - two-player LED ping-pong core; SPEEDUP_EN shortens the ball
// period on every return.  Rev 1.0
//------------------------------------------------------------------------------
module pong_game_core
  import pong_pkg::*;
#(
  parameter int N_LED      = 8,
  parameter int SCORE_W    = 4,
  parameter int WIN_SCORE  = 9,
  parameter int TICK_DIV   = 25000000,
  parameter int SHOW_TICKS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_r,
  input  logic               sw_l,
  output logic [N_LED-1:0]   led,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score_r,
  output logic [SCORE_W-1:0] score_l,
  output logic               point_r,
  output logic               point_l,
  output logic               match_over,
  output logic               winner_l
);

  localparam int POS_W = clog2(N_LED);
  localparam int PER_W = clog2(TICK_DIV + 1);
  localparam int SHW_W = (SHOW_TICKS > 1) ? clog2(SHOW_TICKS) : 1;

  localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(N_LED - 1);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
  localparam logic [SHW_W-1:0]   SHOW_LAST = SHW_W'(SHOW_TICKS - 1);
  localparam logic [N_LED-1:0]   ONE_HOT0  = N_LED'(1);

  state_t             cur_st, nxt_st;
  logic [POS_W-1:0]   pos, pos_n;
  logic               dir, dir_n;
  logic               server_l, server_n;
  logic               blink, blink_n;
  logic [SHW_W-1:0]   show_cnt, show_cnt_n;
  logic [SCORE_W-1:0] score_r_n, score_l_n;
  logic               point_r_n, point_l_n, winner_n;
  logic               sw_r_d, sw_l_d;
  logic               press_r, press_l, recv_press, at_end;
  logic               launch, launch_l, hit, scored, scorer_l;
  logic               tick, clear;
  logic [PER_W-1:0]   period;
  logic [N_LED-1:0]   score_bar;

  assign press_r = sw_r & ~sw_r_d;
  assign press_l = sw_l & ~sw_l_d;
  assign clear   = launch | hit | scored;

`ifdef SPEEDUP_EN
  localparam logic [PER_W-1:0] PER_MAX = PER_W'(TICK_DIV);
  localparam logic [PER_W-1:0] PER_MIN = PER_W'(TICK_DIV >> 2);

  logic [PER_W-1:0] period_n, period_dec;

  assign period_dec = period - (period >> 3);

  always_comb begin
    period_n = period;
    if (scored) begin
      period_n = PER_MAX;
    end else if (hit) begin
      period_n = (period_dec < PER_MIN) ? PER_MIN : period_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      period <= PER_MAX;
    end else begin
      period <= period_n;
    end
  end
`else
  assign period = PER_W'(TICK_DIV);
`endif

  pong_tick_gen #(
    .CNT_W (PER_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .period (period),
    .tick   (tick)
  );

  always_comb begin
    nxt_st     = cur_st;
    pos_n      = pos;
    dir_n      = dir;
    server_n   = server_l;
    blink_n    = blink;
    show_cnt_n = show_cnt;
    score_r_n  = score_r;
    score_l_n  = score_l;
    point_r_n  = 1'b0;
    point_l_n  = 1'b0;
    winner_n   = winner_l;
    launch     = 1'b0;
    launch_l   = 1'b0;
    hit        = 1'b0;
    scored     = 1'b0;
    scorer_l   = 1'b0;
    // the receiver is whoever the ball is heading toward
    recv_press = (dir == LEFTWARD) ? press_l : press_r;
    at_end     = (dir == LEFTWARD) ? (pos == POS_LAST) : (pos == '0);

    case (cur_st)
      S_IDLE: begin
        if (press_r) begin
          launch = 1'b1;
        end else if (press_l) begin
          launch   = 1'b1;
          launch_l = 1'b1;
        end
      end
      S_RALLY: begin
        if (recv_press) begin
          if (at_end) begin
            hit   = 1'b1;
            dir_n = ~dir;
          end else begin
            scored   = 1'b1;
            scorer_l = (dir == RIGHTWARD);
          end
        end else if (tick) begin
          if (at_end) begin
            scored   = 1'b1;
            scorer_l = (dir == RIGHTWARD);
          end else begin
            pos_n = (dir == LEFTWARD) ? pos + POS_W'(1) : pos - POS_W'(1);
          end
        end
      end
      S_SHOW: begin
        if (tick) begin
          if (show_cnt == SHOW_LAST) begin
            nxt_st     = S_SERVE;
            show_cnt_n = '0;
          end else begin
            show_cnt_n = show_cnt + SHW_W'(1);
          end
        end
      end
      S_SERVE: begin
        if (server_l ? press_l : press_r) begin
          launch   = 1'b1;
          launch_l = server_l;
        end
      end
      S_END: begin
        if (tick) begin
          blink_n = ~blink;
        end
        if (press_r || press_l) begin
          nxt_st    = S_IDLE;
          score_r_n = '0;
          score_l_n = '0;
          winner_n  = 1'b0;
          blink_n   = 1'b0;
        end
      end
      default: nxt_st = S_IDLE;
    endcase

    if (launch) begin
      nxt_st = S_RALLY;
      pos_n  = launch_l ? POS_LAST : '0;
      dir_n  = launch_l ? RIGHTWARD : LEFTWARD;
    end

    if (scored) begin
      server_n   = scorer_l;
      show_cnt_n = '0;
      blink_n    = 1'b0;
      if (scorer_l) begin
        score_l_n = score_l + SCORE_W'(1);
        point_l_n = 1'b1;
      end else begin
        score_r_n = score_r + SCORE_W'(1);
        point_r_n = 1'b1;
      end
      if ((scorer_l ? score_l_n : score_r_n) == WIN) begin
        nxt_st   = S_END;
        winner_n = scorer_l;
      end else begin
        nxt_st = S_SHOW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_st   <= S_IDLE;
      pos      <= '0;
      dir      <= RIGHTWARD;
      server_l <= 1'b0;
      blink    <= 1'b0;
      show_cnt <= '0;
      score_r  <= '0;
      score_l  <= '0;
      point_r  <= 1'b0;
      point_l  <= 1'b0;
      winner_l <= 1'b0;
      sw_r_d   <= 1'b0;
      sw_l_d   <= 1'b0;
    end else begin
      cur_st   <= nxt_st;
      pos      <= pos_n;
      dir      <= dir_n;
      server_l <= server_n;
      blink    <= blink_n;
      show_cnt <= show_cnt_n;
      score_r  <= score_r_n;
      score_l  <= score_l_n;
      point_r  <= point_r_n;
      point_l  <= point_l_n;
      winner_l <= winner_n;
      sw_r_d   <= sw_r;
      sw_l_d   <= sw_l;
    end
  end

  always_comb begin
    score_bar                      = '0;
    score_bar[SCORE_W-1:0]         = score_r;
    score_bar[2*SCORE_W-1:SCORE_W] = score_l;
    led                            = '0;
    case (cur_st)
      S_RALLY: led = ONE_HOT0 << pos;
      S_SHOW:  led = score_bar;
      S_SERVE: led = server_l ? (ONE_HOT0 << POS_LAST) : ONE_HOT0;
      S_END: begin
        led = score_bar;
        if (blink) begin
          if (winner_l) begin
            led[2*SCORE_W-1:SCORE_W] = '0;
          end else begin
            led[SCORE_W-1:0] = '0;
          end
        end
      end
      default: led = '0;
    endcase
  end

  assign state      = cur_st;
  assign match_over = (cur_st == S_END);

endmodule
`default_nettype wire

// File: tb/tb_pong_game_core.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// tb_pong_game_core - vector table plus scoreboard bench for pong_game_core.
//------------------------------------------------------------------------------
module tb_pong_game_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw_r = 1'b0;
  logic       sw_l = 1'b0;
  logic [7:0] led;
  logic [2:0] state;
  logic [3:0] score_r, score_l;
  logic       point_r, point_l, match_over, winner_l;

  always #5 clk = ~clk;

  pong_game_core #(
    .N_LED      (8),
    .SCORE_W    (4),
    .WIN_SCORE  (3),
    .TICK_DIV   (4),
    .SHOW_TICKS (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_r       (sw_r),
    .sw_l       (sw_l),
    .led        (led),
    .state      (state),
    .score_r    (score_r),
    .score_l    (score_l),
    .point_r    (point_r),
    .point_l    (point_l),
    .match_over (match_over),
    .winner_l   (winner_l)
  );

`ifdef SPEEDUP_EN
  logic       rst2 = 1'b0;
  logic       sw_r2 = 1'b0;
  logic       sw_l2 = 1'b0;
  logic [7:0] led2;
  logic [2:0] state2;
  logic [3:0] score_r2, score_l2;
  logic       point_r2, point_l2, match_over2, winner_l2;

  pong_game_core #(
    .N_LED      (8),
    .SCORE_W    (4),
    .WIN_SCORE  (9),
    .TICK_DIV   (64),
    .SHOW_TICKS (2)
  ) dut2 (
    .clk        (clk),
    .rst        (rst2),
    .sw_r       (sw_r2),
    .sw_l       (sw_l2),
    .led        (led2),
    .state      (state2),
    .score_r    (score_r2),
    .score_l    (score_l2),
    .point_r    (point_r2),
    .point_l    (point_l2),
    .match_over (match_over2),
    .winner_l   (winner_l2)
  );
`endif

  typedef struct {
    logic [7:0] led;
    logic [2:0] st;
    logic [3:0] sr;
    logic [3:0] sl;
    logic       pr;
    logic       pl;
    logic       mo;
    logic       wl;
  } exp_t;

  typedef struct {
    logic r;
    logic l;
    int   cycles;
    exp_t exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] lv, input logic [2:0] st,
                              input logic [3:0] sr, input logic [3:0] sl,
                              input logic pr, input logic pl, input logic mo, input logic wl);
    exp_t e;
    e.led = lv; e.st = st; e.sr = sr; e.sl = sl;
    e.pr = pr;  e.pl = pl; e.mo = mo; e.wl = wl;
    return e;
  endfunction

  task automatic add(input logic r, input logic l, input int cyc, input logic [7:0] lv,
                     input logic [2:0] st, input logic [3:0] sr, input logic [3:0] sl,
                     input logic pr, input logic pl, input logic mo, input logic wl);
    vec_t v;
    v.r = r; v.l = l; v.cycles = cyc;
    v.exp = mk(lv, st, sr, sl, pr, pl, mo, wl);
    vecs.push_back(v);
  endtask

  task automatic sample(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, ".led"},        led,        e.led);
    check({tag, ".state"},      state,      e.st);
    check({tag, ".score_r"},    score_r,    e.sr);
    check({tag, ".score_l"},    score_l,    e.sl);
    check({tag, ".point_r"},    point_r,    e.pr);
    check({tag, ".point_l"},    point_l,    e.pl);
    check({tag, ".match_over"}, match_over, e.mo);
    if (e.mo) check({tag, ".winner_l"}, winner_l, e.wl);
  endtask

  // drive buttons, queue the expectation, advance, then compare against the queue head
  task automatic apply(input logic r, input logic l, input int cyc, input exp_t e, input string tag);
    sw_r = r;
    sw_l = l;
    sb.push_back(e);
    repeat (cyc) @(posedge clk);
    #1;
    sample(tag);
  endtask

`ifdef SPEEDUP_EN
  task automatic measure2(output int n);
    logic [7:0] prev;
    prev = led2;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (led2 == prev && n < 1000);
  endtask

  task automatic wait_led2(input logic [7:0] target, input string tag);
    int n;
    n = 0;
    while (led2 != target && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, led2, target);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // r l cyc   led    st  sr sl pr pl mo wl
    add(1, 0, 1,  8'h01, 1, 0, 0, 0, 0, 0, 0);  // right serve
    add(1, 0, 4,  8'h02, 1, 0, 0, 0, 0, 0, 0);  // held level, first step
    add(0, 0, 24, 8'h80, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1,  8'h80, 1, 0, 0, 0, 0, 0, 0);  // left return at end
    add(0, 0, 4,  8'h40, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 24, 8'h01, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1,  8'h01, 1, 0, 0, 0, 0, 0, 0);  // right return at end
    add(0, 0, 12, 8'h08, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1,  8'h01, 2, 1, 0, 1, 0, 0, 0);  // early swing by left
    add(0, 0, 1,  8'h01, 2, 1, 0, 0, 0, 0, 0);
    add(0, 0, 6,  8'h01, 2, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1,  8'h01, 3, 1, 0, 0, 0, 0, 0);  // SERVE after 8 cycles
    add(0, 1, 1,  8'h01, 3, 1, 0, 0, 0, 0, 0);  // non-server press ignored
    add(1, 0, 1,  8'h01, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 28, 8'h80, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 3,  8'h80, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1,  8'h02, 2, 2, 0, 1, 0, 0, 0);  // miss at left end
    add(0, 0, 8,  8'h01, 3, 2, 0, 0, 0, 0, 0);
    add(1, 0, 1,  8'h01, 1, 2, 0, 0, 0, 0, 0);
    add(0, 0, 32, 8'h03, 4, 3, 0, 1, 0, 1, 0);  // winning point
    add(0, 0, 4,  8'h00, 4, 3, 0, 0, 0, 1, 0);
    add(0, 0, 4,  8'h03, 4, 3, 0, 0, 0, 1, 0);
    add(0, 1, 1,  8'h00, 0, 0, 0, 0, 0, 0, 0);  // any press leaves END
    add(0, 0, 1,  8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1,  8'h80, 1, 0, 0, 0, 0, 0, 0);  // left serve
    add(0, 0, 4,  8'h40, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1,  8'h10, 2, 0, 1, 0, 1, 0, 0);  // early swing by right
    add(0, 0, 8,  8'h80, 3, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1,  8'h80, 3, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1,  8'h80, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 4,  8'h40, 1, 0, 1, 0, 0, 0, 0);

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(8'h00, 0, 0, 0, 0, 0, 0, 0));
    sample("reset");
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].r, vecs[i].l, vecs[i].cycles, vecs[i].exp, $sformatf("v%0d", i));
    end

    // reset in the middle of a rally
    rst = 1'b0;
    apply(0, 0, 1, mk(8'h00, 0, 0, 0, 0, 0, 0, 0), "mid_reset");
    rst = 1'b1;

    // right button held high across serve, rally and SERVE
    apply(1, 0, 1,  mk(8'h01, 1, 0, 0, 0, 0, 0, 0), "held_serve");
    apply(1, 0, 28, mk(8'h80, 1, 0, 0, 0, 0, 0, 0), "held_rally");
    apply(1, 0, 4,  mk(8'h01, 2, 1, 0, 1, 0, 0, 0), "held_miss");
    apply(1, 0, 8,  mk(8'h01, 3, 1, 0, 0, 0, 0, 0), "held_no_reserve");
    sw_r = 1'b0;

`ifdef SPEEDUP_EN
    begin
      int   n;
      int   p;
      logic recv_l;
      rst2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst2  = 1'b1;
      sw_r2 = 1'b1;
      @(posedge clk);
      #1;
      sw_r2 = 1'b0;
      measure2(n);
      check("sp_first", n, 64);
      p      = 64;
      recv_l = 1'b1;
      for (int k = 0; k < 14; k++) begin
        wait_led2(recv_l ? 8'h80 : 8'h01, $sformatf("sp_reach%0d", k));
        if (recv_l) sw_l2 = 1'b1;
        else        sw_r2 = 1'b1;
        @(posedge clk);
        #1;
        sw_l2 = 1'b0;
        sw_r2 = 1'b0;
        p = p - (p >> 3);
        if (p < 16) p = 16;
        measure2(n);
        check($sformatf("sp_ret%0d", k), n, p);
        recv_l = ~recv_l;
      end
      n = 0;
      while (state2 != 3'd3 && n < 3000) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("sp_serve", state2, 3'd3);
      sw_r2 = 1'b1;
      sw_l2 = 1'b1;
      @(posedge clk);
      #1;
      sw_r2 = 1'b0;
      sw_l2 = 1'b0;
      measure2(n);
      check("sp_reload", n, 64);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
